// File: rtl/bitwise_unit_64_seq_if.sv
// Request/response bundle for the multi-cycle 64-bit bitwise unit.
// The master issues operand pairs and consumes results; the slave is the unit itself.
interface bitwise_unit_64_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] y;
    logic        zero;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, y, zero
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, y, zero
    );
endinterface

// File: rtl/bitwise_unit_64_seq.sv
// Multi-cycle 64-bit AND/OR/XOR/ANDN unit: one SLICE_W-bit slice of y is written per cycle,
// with valid/ready handshakes on both the request and the response side.
module bitwise_unit_64_seq #(
    parameter int SLICE_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bitwise_unit_64_seq_if.slave  bus
);
    localparam int NSLICE = 64 / SLICE_W;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSLICE - 1);

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_XOR  = 2'b10,
        OP_ANDN = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic [63:0]       a_r;
    logic [63:0]       b_r;
    op_t               op_r;
    logic [63:0]       y_r;

    logic [63:0]        a_sh;
    logic [63:0]        b_sh;
    logic [SLICE_W-1:0] slice_res;

    // Shifting the captured operands down keeps the slice mux a plain barrel shift
    // rather than a variable part-select on the read side.
    always_comb begin
        // NOTE: combinational outputs get a default first so no path can infer a latch.
        a_sh      = a_r >> (32'(idx) * SLICE_W);
        b_sh      = b_r >> (32'(idx) * SLICE_W);
        slice_res = '0;
        unique case (op_r)
            OP_AND:  slice_res = a_sh[SLICE_W-1:0] &  b_sh[SLICE_W-1:0];
            OP_OR:   slice_res = a_sh[SLICE_W-1:0] |  b_sh[SLICE_W-1:0];
            OP_XOR:  slice_res = a_sh[SLICE_W-1:0] ^  b_sh[SLICE_W-1:0];
            OP_ANDN: slice_res = a_sh[SLICE_W-1:0] & ~b_sh[SLICE_W-1:0];
        endcase
    end

    // NOTE: every register, operand captures included, is cleared by the async reset so
    // an aborted operation leaves nothing behind for the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            a_r   <= '0;
            b_r   <= '0;
            op_r  <= OP_AND;
            y_r   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_r   <= bus.a;
                        b_r   <= bus.b;
                        op_r  <= op_t'(bus.op);
                        y_r   <= '0;
                        idx   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    y_r[32'(idx) * SLICE_W +: SLICE_W] <= slice_res;
                    if (idx == IDX_LAST) begin
                        idx   <= '0;
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    // A request waiting alongside out_ready is left for the IDLE cycle.
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.y         = y_r;
    assign bus.zero      = (y_r == 64'd0);
endmodule

// File: tb/tb_bitwise_unit_64_seq.sv
// Directed bench for bitwise_unit_64_seq: one unit at SLICE_W=16 for the main sequence,
// plus SLICE_W=1 and SLICE_W=64 instances that only see traffic during the latency sweep.
module tb_bitwise_unit_64_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        sweep_en = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [63:0] a = '0;
    logic [63:0] b = '0;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    bitwise_unit_64_seq_if u_if16 ();
    bitwise_unit_64_seq_if u_if1 ();
    bitwise_unit_64_seq_if u_if64 ();

    assign u_if16.in_valid  = in_valid;
    assign u_if16.op        = op;
    assign u_if16.a         = a;
    assign u_if16.b         = b;
    assign u_if16.out_ready = out_ready;

    assign u_if1.in_valid   = in_valid & sweep_en;
    assign u_if1.op         = op;
    assign u_if1.a          = a;
    assign u_if1.b          = b;
    assign u_if1.out_ready  = out_ready;

    assign u_if64.in_valid  = in_valid & sweep_en;
    assign u_if64.op        = op;
    assign u_if64.a         = a;
    assign u_if64.b         = b;
    assign u_if64.out_ready = out_ready;

    bitwise_unit_64_seq #(.SLICE_W(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(u_if16));
    bitwise_unit_64_seq #(.SLICE_W(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(u_if1));
    bitwise_unit_64_seq #(.SLICE_W(64)) dut64 (.clk(clk), .rst_n(rst_n), .bus(u_if64));

    localparam logic [63:0] AND_A  = 64'hF0F0_F0F0_FFFF_0000;
    localparam logic [63:0] AND_B  = 64'h0FF0_FF00_F0F0_FFFF;
    localparam logic [63:0] AND_Y  = 64'h00F0_F000_F0F0_0000;
    localparam logic [63:0] PAT_A  = 64'hAAAA_AAAA_AAAA_AAAA;
    localparam logic [63:0] PAT_B  = 64'hFFFF_0000_FFFF_0000;
    localparam logic [63:0] OR_Y   = 64'hFFFF_AAAA_FFFF_AAAA;
    localparam logic [63:0] XOR_Y  = 64'h5555_AAAA_5555_AAAA;
    localparam logic [63:0] ANDN_Y = 64'h0000_AAAA_0000_AAAA;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one request; the following rising edge is the acceptance edge.
    task automatic issue(input logic [1:0] o, input logic [63:0] av, input logic [63:0] bv);
        op = o; a = av; b = bv; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Count edges after acceptance until out_valid is seen; optionally scramble a/b each cycle.
    task automatic wait_valid(output int lat, input bit scramble);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            #1;
            if (scramble) begin
                a = ~a ^ 64'(lat);
                b = ~b;
            end
            @(negedge clk);
        end while (!u_if16.out_valid && lat < 200);
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check({tag, "_in_ready_after"}, 64'(u_if16.in_ready), 64'd1);
        check({tag, "_out_valid_after"}, 64'(u_if16.out_valid), 64'd0);
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [63:0] av,
                          input logic [63:0] bv, input logic [63:0] exp_y, input logic exp_zero);
        int lat;
        issue(o, av, bv);
        wait_valid(lat, 1'b0);
        check({tag, "_latency"}, 64'(lat), 64'd4);
        check({tag, "_y"}, u_if16.y, exp_y);
        check({tag, "_zero"}, 64'(u_if16.zero), 64'(exp_zero));
        drain(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int ov_seen;
        int lat1;
        int lat16;
        int lat64;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready", 64'(u_if16.in_ready), 64'd1);
        check("rst_out_valid", 64'(u_if16.out_valid), 64'd0);
        check("rst_y", u_if16.y, 64'd0);
        check("rst_zero", 64'(u_if16.zero), 64'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Main function at SLICE_W=16, each opcode
        run_op("and", 2'b00, AND_A, AND_B, AND_Y, 1'b0);
        run_op("or", 2'b01, PAT_A, PAT_B, OR_Y, 1'b0);
        run_op("xor", 2'b10, PAT_A, PAT_B, XOR_Y, 1'b0);
        run_op("andn", 2'b11, PAT_A, PAT_B, ANDN_Y, 1'b0);

        // Zero flag with operands changing every cycle during RUN
        issue(2'b00, 64'h1234, 64'hEDCB);
        wait_valid(lat, 1'b1);
        check("iso_latency", 64'(lat), 64'd4);
        check("iso_y", u_if16.y, 64'd0);
        check("iso_zero", 64'(u_if16.zero), 64'd1);
        drain("iso");

        // Backpressure with a second request waiting
        issue(2'b00, AND_A, AND_B);
        wait_valid(lat, 1'b0);
        check("bp_latency", 64'(lat), 64'd4);
        op = 2'b01; a = PAT_A; b = PAT_B; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_y_stable", u_if16.y, AND_Y);
            check("bp_in_ready_low", 64'(u_if16.in_ready), 64'd0);
            check("bp_out_valid_held", 64'(u_if16.out_valid), 64'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("bp_idle_in_ready", 64'(u_if16.in_ready), 64'd1);
        check("bp_idle_out_valid", 64'(u_if16.out_valid), 64'd0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("bp_second_accepted", 64'(u_if16.in_ready), 64'd0);
        lat = 0;
        while (!u_if16.out_valid && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("bp_second_latency", 64'(lat), 64'd4);
        check("bp_second_y", u_if16.y, OR_Y);
        drain("bp");

        // Reset mid-RUN: immediate clear and no stale response afterwards
        issue(2'b10, PAT_A, PAT_B);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(u_if16.out_valid), 64'd0);
        check("midrst_in_ready", 64'(u_if16.in_ready), 64'd1);
        check("midrst_y", u_if16.y, 64'd0);
        check("midrst_zero", 64'(u_if16.zero), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        ov_seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (u_if16.out_valid) ov_seen++;
        end
        check("midrst_no_stale", 64'(ov_seen), 64'd0);
        check("midrst_y_after", u_if16.y, 64'd0);

        // Latency sweep across SLICE_W = 1, 16, 64 with the same AND vector
        sweep_en = 1'b1;
        issue(2'b00, AND_A, AND_B);
        lat1 = 0; lat16 = 0; lat64 = 0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (u_if1.out_valid  && lat1  == 0) lat1  = k;
            if (u_if16.out_valid && lat16 == 0) lat16 = k;
            if (u_if64.out_valid && lat64 == 0) lat64 = k;
            if (lat1 != 0 && lat16 != 0 && lat64 != 0) break;
        end
        check("sweep_lat_w1", 64'(lat1), 64'd64);
        check("sweep_lat_w16", 64'(lat16), 64'd4);
        check("sweep_lat_w64", 64'(lat64), 64'd1);
        check("sweep_y_w1", u_if1.y, AND_Y);
        check("sweep_y_w16", u_if16.y, AND_Y);
        check("sweep_y_w64", u_if64.y, AND_Y);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        sweep_en = 1'b0;
        @(negedge clk);
        check("sweep_w1_idle", 64'(u_if1.in_ready), 64'd1);
        check("sweep_w64_idle", 64'(u_if64.in_ready), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
